// File: rtl/lag_check_sequencer_if.sv
// Bus between software registers and the lag check sequencer:
// control word and sync inputs in, readback registers out.
interface lag_check_sequencer_if #(
    parameter int CNT_WIDTH = 24
) ();
    logic [31:0]          ctrl_in;
    logic                 sync_ref;
    logic                 sync_dut;
    logic [CNT_WIDTH-1:0] lag_out;
    logic [CNT_WIDTH-1:0] lag_max_out;
    logic [31:0]          status_out;

    modport master (
        output ctrl_in, sync_ref, sync_dut,
        input  lag_out, lag_max_out, status_out
    );

    modport slave (
        input  ctrl_in, sync_ref, sync_dut,
        output lag_out, lag_max_out, status_out
    );
endinterface

// File: rtl/lag_check_sequencer.sv
// Measures cycles from a reference sync rising edge to a datapath sync rising
// edge; keeps last and maximum lag under software arm/clear/timeout control.
module lag_check_sequencer #(
    parameter int CNT_WIDTH    = 24,
    parameter int MCOUNT_WIDTH = 16
) (
    input  logic                  OPB_Clk,
    input  logic                  OPB_Rst,
    lag_check_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_COUNTING = 3'd2,
        S_DONE     = 3'd3,
        S_TIMEOUT  = 3'd4
    } state_t;

    state_t                  state_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic [CNT_WIDTH-1:0]    lag_r;
    logic [CNT_WIDTH-1:0]    lag_max_r;
    logic [MCOUNT_WIDTH-1:0] mcount_r;
    logic                    done_r;
    logic                    timeout_r;
    logic                    sat_r;
    logic                    arm_q_r;
    logic                    ref_q_r;
    logic                    dut_q_r;

    logic                    arm_rise_s;
    logic                    ref_rise_s;
    logic                    dut_rise_s;
    logic                    clear_s;
    logic [32:0]             tmo_field_s;
    logic [CNT_WIDTH-1:0]    tmo_s;
    logic [CNT_WIDTH-1:0]    cnt_max_s;
    logic [CNT_WIDTH-1:0]    cnt_inc_s;
    logic [CNT_WIDTH-1:0]    lag_s;
    logic [CNT_WIDTH-1:0]    lag_max_nxt_s;
    logic                    tmo_hit_s;
    logic                    busy_s;
    logic [31:0]             mcount_ext_s;
    logic                    unused_ok_s;

    assign arm_rise_s  = bus.ctrl_in[0] & ~arm_q_r;
    assign ref_rise_s  = bus.sync_ref & ~ref_q_r;
    assign dut_rise_s  = bus.sync_dut & ~dut_q_r;
    assign clear_s     = bus.ctrl_in[1];
    // Widened by one bit so the unused upper slice is never empty at CNT_WIDTH=32.
    assign tmo_field_s = {9'd0, bus.ctrl_in[31:8]};
    assign tmo_s       = tmo_field_s[CNT_WIDTH-1:0];
    assign cnt_max_s   = {CNT_WIDTH{1'b1}};
    assign cnt_inc_s   = (cnt_r == cnt_max_s) ? cnt_r : cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign tmo_hit_s   = (tmo_s != {CNT_WIDTH{1'b0}}) && (cnt_inc_s >= tmo_s);
    assign unused_ok_s = ^{bus.ctrl_in[7:2], tmo_field_s[32:CNT_WIDTH]};

    // Lag is the count including the dut edge cycle; zero when both edges coincide in ARMED.
    always_comb begin
        lag_s         = {CNT_WIDTH{1'b0}};
        lag_max_nxt_s = lag_max_r;
        if (state_r == S_COUNTING) begin
            lag_s = cnt_inc_s;
        end else begin
            lag_s = {CNT_WIDTH{1'b0}};
        end
        if (lag_s > lag_max_r) begin
            lag_max_nxt_s = lag_s;
        end else begin
            lag_max_nxt_s = lag_max_r;
        end
    end

    // Sequencer state, counters, results and flags.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            lag_r     <= {CNT_WIDTH{1'b0}};
            lag_max_r <= {CNT_WIDTH{1'b0}};
            mcount_r  <= {MCOUNT_WIDTH{1'b0}};
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            sat_r     <= 1'b0;
            arm_q_r   <= 1'b1;
            ref_q_r   <= 1'b0;
            dut_q_r   <= 1'b0;
        end else begin
            arm_q_r <= bus.ctrl_in[0];
            ref_q_r <= bus.sync_ref;
            dut_q_r <= bus.sync_dut;
            if (clear_s) begin
                state_r   <= S_IDLE;
                cnt_r     <= {CNT_WIDTH{1'b0}};
                lag_r     <= {CNT_WIDTH{1'b0}};
                lag_max_r <= {CNT_WIDTH{1'b0}};
                mcount_r  <= {MCOUNT_WIDTH{1'b0}};
                done_r    <= 1'b0;
                timeout_r <= 1'b0;
                sat_r     <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        done_r    <= 1'b0;
                        timeout_r <= 1'b0;
                        sat_r     <= 1'b0;
                        if (arm_rise_s) begin
                            state_r <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (ref_rise_s && dut_rise_s) begin
                            state_r   <= S_DONE;
                            lag_r     <= lag_s;
                            lag_max_r <= lag_max_nxt_s;
                            mcount_r  <= mcount_r + {{(MCOUNT_WIDTH-1){1'b0}}, 1'b1};
                            done_r    <= 1'b1;
                        end else if (ref_rise_s) begin
                            state_r <= S_COUNTING;
                            cnt_r   <= {CNT_WIDTH{1'b0}};
                        end
                    end
                    S_COUNTING: begin
                        cnt_r <= cnt_inc_s;
                        if (cnt_r == cnt_max_s) begin
                            sat_r <= 1'b1;
                        end
                        // A dut edge on the timeout cycle still completes the measurement.
                        if (dut_rise_s) begin
                            state_r   <= S_DONE;
                            lag_r     <= lag_s;
                            lag_max_r <= lag_max_nxt_s;
                            mcount_r  <= mcount_r + {{(MCOUNT_WIDTH-1){1'b0}}, 1'b1};
                            done_r    <= 1'b1;
                        end else if (tmo_hit_s) begin
                            state_r   <= S_TIMEOUT;
                            timeout_r <= 1'b1;
                        end
                    end
                    S_DONE, S_TIMEOUT: begin
                        if (arm_rise_s) begin
                            state_r   <= S_ARMED;
                            done_r    <= 1'b0;
                            timeout_r <= 1'b0;
                            sat_r     <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_s         = (state_r == S_ARMED) || (state_r == S_COUNTING);
    assign mcount_ext_s   = 32'(mcount_r);
    assign bus.lag_out     = lag_r;
    assign bus.lag_max_out = lag_max_r;
    assign bus.status_out  = {mcount_ext_s[15:0], 9'd0, state_r, sat_r, timeout_r, done_r, busy_s};
endmodule

// File: doc/lag_check_sequencer.md
Name: lag_check_sequencer

Overview:
- Software-controlled lag measurement sequencer in the OPB_Clk domain.
- Control comes from a ppc2simulink software register word (arm/clear/timeout). Results go to simulink2ppc readback registers.
- Measures the cycle count from a reference sync edge to a datapath sync edge. Keeps the last and maximum lag, sequenced by an arm/count/done state machine.

Parameters:
- CNT_WIDTH, 24, width of lag counter and lag result fields (8..32).
- MCOUNT_WIDTH, 16, width of completed-measurement counter.

Ports:
- OPB_Clk  input  1  system clock; all logic on rising edge.
- OPB_Rst  input  1  asynchronous, active-high reset.
- ctrl_in  input  32  software control word: bit0 arm, bit1 clear, bits[31:8] timeout cycles (0 = no timeout).
- sync_ref  input  1  reference sync (e.g. PPS/frame start), level, synchronous to OPB_Clk.
- sync_dut  input  1  datapath sync under test, level, synchronous.
- lag_out  output  CNT_WIDTH  last measured lag in cycles.
- lag_max_out  output  CNT_WIDTH  maximum lag since last clear.
- status_out  output  32  bit0 busy, bit1 done, bit2 timeout, bit3 saturated, bits[6:4] state code, bits[31:16] measurement count (low MCOUNT_WIDTH bits, rest 0).

Behaviour:
- Reset (async, OPB_Rst=1):
  - state=IDLE; lag_out, lag_max_out, status_out, counters all 0.
  - arm edge register = 1, so an arm bit already high at reset release is not an edge.
  - sync edge registers = 0.
- Edge detection: arm_rise = ctrl_in[0] & ~arm_q; ref_rise and dut_rise are formed likewise from sync_ref and sync_dut. A pulse longer than one cycle counts once. Both syncs see identical detection delay, so lag is unaffected.
- State codes: IDLE=0, ARMED=1, COUNTING=2, DONE=3, TIMEOUT=4.
- IDLE:
  - arm_rise -> ARMED.
  - Clear done, timeout and saturated flags; lag_out and lag_max_out keep their values.
- ARMED:
  - ref_rise -> COUNTING with cnt=0.
  - ref_rise and dut_rise in the same cycle -> DONE, lag 0.
  - No timeout in ARMED; waits indefinitely.
- COUNTING:
  - cnt increments each cycle.
  - dut_rise k cycles after the ref_rise cycle -> DONE with lag_out=k.
  - cnt saturates at all-ones and sets the saturated flag; it never wraps.
  - ref_rise while COUNTING is ignored (first ref edge wins).
  - If timeout!=0 and cnt reaches timeout (truncated to CNT_WIDTH) without dut_rise -> TIMEOUT. lag_out is unchanged; the timeout flag is set.
  - dut_rise in the same cycle as the timeout hit -> DONE (dut wins).
- DONE entry, registered:
  - lag_out updates; lag_max_out = max(lag_max_out, lag).
  - Measurement count increments and wraps at 2^MCOUNT_WIDTH.
  - done flag set.
  - All outputs visible the cycle after the dut_rise cycle (1-cycle latency).
- DONE/TIMEOUT: hold results. arm_rise -> ARMED directly (re-arm without clear); flags clear on entry to ARMED.
- Clear: ctrl_in[1]=1 is level-sensitive and applies in any state.
  - Next state IDLE.
  - Zeroes lag_out, lag_max_out, measurement count and flags.
  - Clear has priority over arm_rise and over a dut_rise in the same cycle.
  - Held clear keeps the block in IDLE and ignores arm.
- busy = state is ARMED or COUNTING. status_out is fully registered, with no combinational path from inputs.
- Timeout field is sampled continuously. A change mid-COUNTING takes effect immediately; the compare is equality-or-greater, so lowering timeout below cnt fires TIMEOUT next cycle.

Test Plan:
- Basic: reset, arm rise, ref pulse at cycle 100, dut pulse at cycle 137 -> lag_out=37, done=1, busy=0, count=1, lag_max_out=37; outputs valid 1 cycle after dut.
- Same-cycle and max: ref and dut high in the same cycle -> lag 0. Then re-arm (no clear) with lag 50, then lag 20 -> lag_out=20, lag_max_out=50, count=3.
- Timeout: ctrl timeout=10, arm, ref, no dut -> TIMEOUT state (code 4), status bit2=1, lag_out unchanged. Variant with dut on the timeout cycle -> DONE, lag=10.
- Saturation: CNT_WIDTH=8, timeout=0, ref then dut after 300 cycles -> lag_out=255, saturated=1.
- Clear priority: clear asserted together with arm rise and, separately, together with dut_rise in COUNTING -> IDLE, all results 0. Holding arm high across clear release gives no new measurement.
- Reset mid-operation: assert OPB_Rst asynchronously (between clock edges) during COUNTING -> outputs 0 immediately. Arm held high through release does not re-arm; a fresh 0->1 arm does.
